// File: rtl/hv_sram_arbiter_if.sv
// Handshake bundle for hv_sram_arbiter: requester request/response channels plus the shared SRAM port.
// slave is the arbiter side; master is the requesters together with the SRAM.
interface hv_sram_arbiter_if #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            ReqValid_SI;
  logic [NUM_REQ*ADDR_WIDTH-1:0] ReqAddr_DI;
  logic [NUM_REQ-1:0]            ReqReady_SO;
  logic [NUM_REQ-1:0]            RspValid_SO;
  logic [DATA_WIDTH-1:0]         RspData_DO;
  logic [NUM_REQ-1:0]            RspReady_SI;
  logic                          SramValid_SO;
  logic [ADDR_WIDTH-1:0]         SramAddr_DO;
  logic                          SramReady_SI;
  logic                          SramRspValid_SI;
  logic [DATA_WIDTH-1:0]         SramRspData_DI;
  logic                          Busy_SO;

  modport slave (
    input  ReqValid_SI, ReqAddr_DI, RspReady_SI, SramReady_SI, SramRspValid_SI, SramRspData_DI,
    output ReqReady_SO, RspValid_SO, RspData_DO, SramValid_SO, SramAddr_DO, Busy_SO
  );

  modport master (
    output ReqValid_SI, ReqAddr_DI, RspReady_SI, SramReady_SI, SramRspValid_SI, SramRspData_DI,
    input  ReqReady_SO, RspValid_SO, RspData_DO, SramValid_SO, SramAddr_DO, Busy_SO
  );
endinterface

// File: rtl/hv_sram_arbiter.sv
// Arbitrates NUM_REQ modality readers onto one shared SRAM read port, one transaction at a time.
// Define HV_ARB_RR_EN for round-robin arbitration; otherwise the lowest requester index wins.
module hv_sram_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic              Clk_CI,
  input logic              Reset_RI,
  hv_sram_arbiter_if.slave bus
);
  localparam int unsigned GrantWidth = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDeliver} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [GrantWidth-1:0]   grant_q;
  logic                    sram_valid_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic                    grant_valid;
  logic [GrantWidth-1:0]   grant_idx;
  logic [NUM_REQ-1:0]      req_ready;

`ifdef HV_ARB_RR_EN
  logic [GrantWidth-1:0]   ptr_q;

  // First valid requester at or after the pointer, wrapping around.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      logic [GrantWidth-1:0] idx;
      idx = GrantWidth'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_valid && bus.ReqValid_SI[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end
`else
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.ReqValid_SI[i]) begin
        grant_valid = 1'b1;
        grant_idx   = GrantWidth'(i);
      end
    end
  end
`endif

  // Acceptance is combinational so a waiting requester is released in its grant cycle.
  always_comb begin
    req_ready = '0;
    if (Reset_RI && (state_q == StIdle) && grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      grant_q      <= '0;
      sram_valid_q <= 1'b0;
      rsp_valid_q  <= '0;
`ifdef HV_ARB_RR_EN
      ptr_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            addr_q       <= bus.ReqAddr_DI[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
            grant_q      <= grant_idx;
            sram_valid_q <= 1'b1;
            state_q      <= StIssue;
`ifdef HV_ARB_RR_EN
            ptr_q        <= (32'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
`endif
          end
        end
        StIssue: begin
          if (bus.SramReady_SI) begin
            sram_valid_q <= 1'b0;
            state_q      <= StWait;
          end
        end
        StWait: begin
          if (bus.SramRspValid_SI) begin
            data_q      <= bus.SramRspData_DI;
            rsp_valid_q <= NUM_REQ'(1) << grant_q;
            state_q     <= StDeliver;
          end
        end
        StDeliver: begin
          if (bus.RspReady_SI[grant_q]) begin
            rsp_valid_q <= '0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ReqReady_SO  = req_ready;
  assign bus.RspValid_SO  = rsp_valid_q;
  assign bus.RspData_DO   = data_q;
  assign bus.SramValid_SO = sram_valid_q;
  assign bus.SramAddr_DO  = addr_q;
  assign bus.Busy_SO      = (state_q != StIdle);
endmodule

// File: tb/tb_hv_sram_arbiter.sv
// Self-checking bench for hv_sram_arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of arbitration and the request/SRAM/response handshakes.
module tb_hv_sram_arbiter;
  localparam int N  = 3;
  localparam int AW = 6;
  localparam int DW = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int tests_run    = 0;
  int tests_failed = 0;
  int model_ptr    = 0;

  hv_sram_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  hv_sram_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk_CI   (clk),
    .Reset_RI (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  // Winner is the first valid requester at or after the pointer; the pointer stays 0 when
  // round-robin is disabled, which gives lowest-index priority.
  function automatic int model_pick(input logic [N-1:0] m, input int p);
    model_pick = -1;
    for (int k = N - 1; k >= 0; k--) if (m[(p + k) % N]) model_pick = (p + k) % N;
  endfunction

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.ReqValid_SI     = '0;
    bus.ReqAddr_DI      = '0;
    bus.RspReady_SI     = '0;
    bus.SramReady_SI    = 1'b0;
    bus.SramRspValid_SI = 1'b0;
    bus.SramRspData_DI  = '0;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    bus.ReqAddr_DI[i*AW +: AW] = a;
  endtask

  task automatic apply_reset();
    drive_idle();
    rst_n     = 1'b0;
    model_ptr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ReqValid_SI     = '1;
    bus.ReqAddr_DI      = '1;
    bus.RspReady_SI     = '1;
    bus.SramReady_SI    = 1'b1;
    bus.SramRspValid_SI = 1'b1;
    bus.SramRspData_DI  = '1;
    repeat (2) @(negedge clk);
    tests_run++; if (bus.ReqReady_SO !== 3'b000) begin tests_failed++;
      $display("FAIL reset_req_ready: got %b want 000", bus.ReqReady_SO); end
    tests_run++; if (bus.RspValid_SO !== 3'b000) begin tests_failed++;
      $display("FAIL reset_rsp_valid: got %b want 000", bus.RspValid_SO); end
    tests_run++; if (bus.SramValid_SO !== 1'b0) begin tests_failed++;
      $display("FAIL reset_sram_valid: got %b want 0", bus.SramValid_SO); end
    tests_run++; if (bus.Busy_SO !== 1'b0) begin tests_failed++;
      $display("FAIL reset_busy: got %b want 0", bus.Busy_SO); end
    tests_run++; if (bus.SramAddr_DO !== '0) begin tests_failed++;
      $display("FAIL reset_sram_addr: got %h want 0", bus.SramAddr_DO); end
    tests_run++; if (bus.RspData_DO !== '0) begin tests_failed++;
      $display("FAIL reset_rsp_data: got %h want 0", bus.RspData_DO); end
    drive_idle();
    next();
    rst_n     = 1'b1;
    model_ptr = 0;
    @(negedge clk);
    tests_run++; if (bus.Busy_SO !== 1'b0 || bus.ReqReady_SO !== 3'b000) begin tests_failed++;
      $display("FAIL reset_release_idle: got busy=%b ready=%b want 0/000", bus.Busy_SO,
               bus.ReqReady_SO); end
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = $urandom;
    apply_reset();
    bus.ReqValid_SI  = 3'b001;
    set_addr(0, 6'd5);
    set_addr(1, 6'd7);
    bus.SramReady_SI = 1'b1;
    @(negedge clk);
    tests_run++; if (bus.ReqReady_SO !== 3'b001 || bus.Busy_SO !== 1'b0) begin tests_failed++;
      $display("FAIL single_grant: got ready=%b busy=%b want 001/0", bus.ReqReady_SO,
               bus.Busy_SO); end
    next();
    bus.ReqValid_SI = '0;
    @(negedge clk);
    tests_run++;
    if (bus.SramValid_SO !== 1'b1 || bus.SramAddr_DO !== 6'd5 || bus.Busy_SO !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_issue: got valid=%b addr=%0d busy=%b want 1/5/1", bus.SramValid_SO,
               bus.SramAddr_DO, bus.Busy_SO); end
    next();
    bus.SramRspValid_SI = 1'b1;
    bus.SramRspData_DI  = d;
    @(negedge clk);
    tests_run++; if (bus.SramValid_SO !== 1'b0 || bus.RspValid_SO !== 3'b000) begin
      tests_failed++;
      $display("FAIL single_wait: got sram_valid=%b rsp_valid=%b want 0/000", bus.SramValid_SO,
               bus.RspValid_SO); end
    next();
    bus.SramRspValid_SI = 1'b0;
    bus.RspReady_SI     = 3'b001;
    @(negedge clk);
    tests_run++; if (bus.RspValid_SO !== 3'b001 || bus.RspData_DO !== d) begin tests_failed++;
      $display("FAIL single_deliver: got valid=%b data=%h want 001/%h", bus.RspValid_SO,
               bus.RspData_DO, d); end
    next();
    bus.RspReady_SI = '0;
    @(negedge clk);
    tests_run++; if (bus.RspValid_SO !== 3'b000 || bus.Busy_SO !== 1'b0) begin tests_failed++;
      $display("FAIL single_done: got valid=%b busy=%b want 000/0", bus.RspValid_SO,
               bus.Busy_SO); end
  endtask

  task automatic test_arb_order();
    int ng;
    int gi [4];
    int gc [4];
    int exp_g [4];
    bit drop;
    ng   = 0;
    drop = 1'b0;
`ifdef HV_ARB_RR_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 1, 1};
`endif
    apply_reset();
    bus.ReqValid_SI = 3'b111;
    for (int i = 0; i < N; i++) set_addr(i, AW'(i + 1));
    bus.SramReady_SI    = 1'b1;
    bus.SramRspValid_SI = 1'b1;
    bus.SramRspData_DI  = $urandom;
    bus.RspReady_SI     = 3'b111;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(negedge clk);
      if (bus.ReqReady_SO !== 3'b000) begin
        gi[ng] = -1;
        for (int i = 0; i < N; i++) if (bus.ReqReady_SO[i]) gi[ng] = i;
        gc[ng] = c;
        ng++;
`ifndef HV_ARB_RR_EN
        if (ng == 2) drop = 1'b1;
`endif
      end
      next();
      if (drop) bus.ReqValid_SI[0] = 1'b0;
    end
    tests_run++; if (ng != 4) begin tests_failed++;
      $display("FAIL arb_grant_count: got %0d grants want 4 within 40 cycles", ng); end
    for (int k = 0; k < ng; k++) begin
      tests_run++; if (gi[k] != exp_g[k]) begin tests_failed++;
        $display("FAIL arb_order[%0d]: got %0d want %0d", k, gi[k], exp_g[k]); end
      if (k > 0) begin
        tests_run++; if (gc[k] - gc[k-1] != 4) begin tests_failed++;
          $display("FAIL arb_period[%0d]: got %0d want 4", k, gc[k] - gc[k-1]); end
      end
    end
    drive_idle();
  endtask

  task automatic test_back_pressure();
    logic [DW-1:0] d;
    d = $urandom;
    apply_reset();
    bus.ReqValid_SI = 3'b010;
    set_addr(1, 6'd9);
    @(negedge clk);
    tests_run++; if (bus.ReqReady_SO !== 3'b010) begin tests_failed++;
      $display("FAIL bp_grant: got %b want 010", bus.ReqReady_SO); end
    next();
    bus.ReqValid_SI     = 3'b101;
    bus.SramRspValid_SI = 1'b1;
    bus.SramRspData_DI  = ~d;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.SramValid_SO !== 1'b1 || bus.SramAddr_DO !== 6'd9 || bus.ReqReady_SO !== 3'b000)
      begin
        tests_failed++;
        $display("FAIL bp_issue_stall[%0d]: got valid=%b addr=%0d ready=%b want 1/9/000", k,
                 bus.SramValid_SO, bus.SramAddr_DO, bus.ReqReady_SO); end
      next();
    end
    bus.SramReady_SI    = 1'b1;
    bus.SramRspValid_SI = 1'b0;
    @(negedge clk);
    next();
    bus.SramReady_SI    = 1'b0;
    bus.SramRspValid_SI = 1'b1;
    bus.SramRspData_DI  = d;
    @(negedge clk);
    next();
    bus.SramRspData_DI = ~d;
    bus.RspReady_SI    = 3'b101;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (bus.RspValid_SO !== 3'b010 || bus.RspData_DO !== d || bus.ReqReady_SO !== 3'b000)
      begin
        tests_failed++;
        $display("FAIL bp_deliver_stall[%0d]: got valid=%b data=%h ready=%b want 010/%h/000",
                 k, bus.RspValid_SO, bus.RspData_DO, bus.ReqReady_SO, d); end
      next();
    end
    bus.RspReady_SI = 3'b010;
    bus.ReqValid_SI = '0;
    next();
    drive_idle();
    @(negedge clk);
    tests_run++; if (bus.RspValid_SO !== 3'b000 || bus.Busy_SO !== 1'b0) begin tests_failed++;
      $display("FAIL bp_done: got valid=%b busy=%b want 000/0", bus.RspValid_SO, bus.Busy_SO);
    end
  endtask

  task automatic test_stray();
    drive_idle();
    next();
    bus.SramRspValid_SI = 1'b1;
    bus.SramRspData_DI  = $urandom;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++; if (bus.RspValid_SO !== 3'b000 || bus.Busy_SO !== 1'b0) begin tests_failed++;
        $display("FAIL stray_rsp[%0d]: got valid=%b busy=%b want 000/0", k, bus.RspValid_SO,
                 bus.Busy_SO); end
      next();
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    d = $urandom;
    apply_reset();
    bus.ReqValid_SI  = 3'b001;
    set_addr(0, 6'h2a);
    bus.SramReady_SI = 1'b1;
    next();
    bus.ReqValid_SI = '0;
    next();
    @(negedge clk);
    tests_run++; if (bus.Busy_SO !== 1'b1) begin tests_failed++;
      $display("FAIL rstmid_in_wait: got busy=%b want 1", bus.Busy_SO); end
    #1;
    bus.ReqValid_SI = 3'b001;
    set_addr(0, 6'h13);
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.ReqReady_SO !== 3'b000 || bus.RspValid_SO !== 3'b000 || bus.SramValid_SO !== 1'b0 ||
        bus.Busy_SO !== 1'b0 || bus.SramAddr_DO !== '0 || bus.RspData_DO !== '0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: got rdy=%b rv=%b sv=%b busy=%b addr=%h data=%h want all 0",
               bus.ReqReady_SO, bus.RspValid_SO, bus.SramValid_SO, bus.Busy_SO,
               bus.SramAddr_DO, bus.RspData_DO); end
    next();
    bus.SramRspValid_SI = 1'b1;
    bus.SramRspData_DI  = ~d;
    next();
    rst_n               = 1'b1;
    bus.SramRspValid_SI = 1'b0;
    @(negedge clk);
    tests_run++;
    if (bus.Busy_SO !== 1'b0 || bus.RspValid_SO !== 3'b000 || bus.ReqReady_SO !== 3'b001) begin
      tests_failed++;
      $display("FAIL rstmid_after: got busy=%b rv=%b rdy=%b want 0/000/001", bus.Busy_SO,
               bus.RspValid_SO, bus.ReqReady_SO); end
    next();
    bus.ReqValid_SI = '0;
    @(negedge clk);
    tests_run++; if (bus.SramValid_SO !== 1'b1 || bus.SramAddr_DO !== 6'h13) begin
      tests_failed++;
      $display("FAIL rstmid_reissue: got valid=%b addr=%h want 1/13", bus.SramValid_SO,
               bus.SramAddr_DO); end
    next();
    bus.SramRspValid_SI = 1'b1;
    bus.SramRspData_DI  = d;
    next();
    bus.SramRspValid_SI = 1'b0;
    bus.RspReady_SI     = 3'b001;
    @(negedge clk);
    tests_run++; if (bus.RspValid_SO !== 3'b001 || bus.RspData_DO !== d) begin tests_failed++;
      $display("FAIL rstmid_deliver: got valid=%b data=%h want 001/%h", bus.RspValid_SO,
               bus.RspData_DO, d); end
    next();
    drive_idle();
  endtask

  task automatic test_random(input int cycles);
    logic [N-1:0]  pend;
    logic [AW-1:0] paddr [N];
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    logic [DW-1:0] drv_data;
    logic [N-1:0]  exp_rdy;
    logic [N-1:0]  exp_rsp;
    bit outst, cmd_done, data_got, srv;
    int g, exp_g, done_cnt;
    pend = '0; outst = 0; cmd_done = 0; data_got = 0; g = 0; done_cnt = 0;
    cur_addr = '0; cur_data = '0;
    for (int i = 0; i < N; i++) paddr[i] = '0;
    apply_reset();
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i]  = 1'b1;
          paddr[i] = AW'($urandom);
        end
        set_addr(i, pend[i] ? paddr[i] : AW'($urandom));
      end
      bus.ReqValid_SI     = pend;
      bus.SramReady_SI    = ($urandom_range(1) == 1);
      srv                 = ($urandom_range(2) == 0);
      drv_data            = $urandom;
      bus.SramRspValid_SI = srv;
      bus.SramRspData_DI  = drv_data;
      bus.RspReady_SI     = N'($urandom);
      @(negedge clk);
      exp_g   = outst ? -1 : model_pick(pend, model_ptr);
      exp_rdy = (exp_g < 0) ? '0 : N'(1) << exp_g;
      exp_rsp = (outst && data_got) ? N'(1) << g : '0;
      tests_run++; if (bus.ReqReady_SO !== exp_rdy) begin tests_failed++;
        $display("FAIL rand_ready c%0d: got %b want %b", c, bus.ReqReady_SO, exp_rdy); end
      tests_run++; if (bus.Busy_SO !== outst) begin tests_failed++;
        $display("FAIL rand_busy c%0d: got %b want %b", c, bus.Busy_SO, outst); end
      tests_run++; if (bus.SramValid_SO !== (outst && !cmd_done)) begin tests_failed++;
        $display("FAIL rand_sram_valid c%0d: got %b want %b", c, bus.SramValid_SO,
                 outst && !cmd_done); end
      if (outst && !cmd_done) begin
        tests_run++; if (bus.SramAddr_DO !== cur_addr) begin tests_failed++;
          $display("FAIL rand_sram_addr c%0d: got %h want %h", c, bus.SramAddr_DO, cur_addr);
        end
      end
      tests_run++; if (bus.RspValid_SO !== exp_rsp) begin tests_failed++;
        $display("FAIL rand_rsp_valid c%0d: got %b want %b", c, bus.RspValid_SO, exp_rsp); end
      if (outst && data_got) begin
        tests_run++; if (bus.RspData_DO !== cur_data) begin tests_failed++;
          $display("FAIL rand_rsp_data c%0d: got %h want %h", c, bus.RspData_DO, cur_data); end
      end
      if (exp_g >= 0) begin
        outst    = 1'b1;
        g        = exp_g;
        cur_addr = paddr[g];
        pend[g]  = 1'b0;
`ifdef HV_ARB_RR_EN
        model_ptr = (g + 1) % N;
`endif
      end else if (outst && !cmd_done) begin
        if (bus.SramReady_SI) cmd_done = 1'b1;
      end else if (outst && !data_got) begin
        if (srv) begin
          data_got = 1'b1;
          cur_data = drv_data;
        end
      end else if (outst && bus.RspReady_SI[g]) begin
        outst    = 1'b0;
        cmd_done = 1'b0;
        data_got = 1'b0;
        done_cnt++;
      end
      next();
    end
    tests_run++; if (done_cnt < cycles / 20) begin tests_failed++;
      $display("FAIL rand_progress: got %0d transactions want at least %0d", done_cnt,
               cycles / 20); end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single();
    test_arb_order();
    test_back_pressure();
    test_stray();
    test_reset_mid();
    test_random(600);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
